// File: rtl/npu_sram_stream_reader_if.sv
// Bundles the SRAM port-2 bus and the output valid/ready stream of the
// strided stream reader.
//   master: reader side (drives SRAM address/controls and the stream)
//   slave : environment side (SRAM read data and stream ready)
interface npu_sram_stream_reader_if #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] sram_address;
    logic              sram_chipselect;
    logic              sram_write;
    logic [1:0]        sram_byteenable;
    logic              sram_clken;
    logic [DATA_W-1:0] sram_readdata;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output sram_address, sram_chipselect, sram_write, sram_byteenable, sram_clken,
        input  sram_readdata,
        output out_data, out_valid, out_last,
        input  out_ready
    );

    modport slave (
        input  sram_address, sram_chipselect, sram_write, sram_byteenable, sram_clken,
        output sram_readdata,
        input  out_data, out_valid, out_last,
        output out_ready
    );
endinterface

// File: rtl/npu_sram_stream_reader.sv
// Strided SRAM read engine: fetches `length` words starting at `base_addr`
// with address step `stride` (mod 2^ADDR_W) and streams them out through a
// 2-entry buffer. Issue is credit-gated so the 1-cycle SRAM latency never
// overflows the buffer and full throughput holds under backpressure.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   start/base_addr/length/stride command, sampled only when idle
//   busy, done                   command status
//   bus (master)                 SRAM port-2 bus and output stream
module npu_sram_stream_reader #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned DATA_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [ADDR_W-1:0]   stride,
    output logic                busy,
    output logic                done,
    npu_sram_stream_reader_if.master bus
);
    localparam int unsigned LEN_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         cur_addr_q, cur_addr_d;
    logic [LEN_W-1:0]          remaining_q, remaining_d;
    logic [ADDR_W-1:0]         stride_q, stride_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      inflight_q, inflight_d;
    logic                      inflight_last_q, inflight_last_d;
    logic [1:0][DATA_W-1:0]    mem_q, mem_d;
    logic [1:0]                last_q, last_d;
    logic                      wr_ptr_q, wr_ptr_d;
    logic                      rd_ptr_q, rd_ptr_d;
    logic [1:0]                count_q, count_d;

    logic                      pop_c;
    logic                      credit_ok_c;
    logic                      issue_c;
    logic                      issue_last_c;

    // A slot is free next cycle if buffered + in-flight words, minus this
    // cycle's pop, leave room; using the pop keeps 1 word/cycle sustained.
    assign pop_c       = (count_q != 2'd0) && bus.out_ready;
    assign credit_ok_c = (3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop_c));

    // Next-state, issue and buffer update.
    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        remaining_d     = remaining_q;
        stride_d        = stride_q;
        done_d          = 1'b0;
        issue_c         = 1'b0;
        issue_last_c    = 1'b0;
        mem_d           = mem_q;
        last_d          = last_q;
        wr_ptr_d        = wr_ptr_q;
        rd_ptr_d        = rd_ptr_q;
        count_d         = count_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (length != LEN_W'(0)) begin
                        cur_addr_d  = base_addr;
                        remaining_d = length;
                        stride_d    = stride;
                        state_d     = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (credit_ok_c) begin
                    issue_c     = 1'b1;
                    cur_addr_d  = cur_addr_q + stride_q;
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        issue_last_c = 1'b1;
                        state_d      = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop_c && last_q[rd_ptr_q]) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Read data returning from last cycle's issue lands in the buffer.
        if (inflight_q) begin
            mem_d[wr_ptr_q]  = bus.sram_readdata;
            last_d[wr_ptr_q] = inflight_last_q;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop_c) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(inflight_q) - 2'(pop_c);

        inflight_d      = issue_c;
        inflight_last_d = issue_last_c;
        busy_d          = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cur_addr_q      <= '0;
            remaining_q     <= '0;
            stride_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            mem_q           <= '0;
            last_q          <= '0;
            wr_ptr_q        <= 1'b0;
            rd_ptr_q        <= 1'b0;
            count_q         <= '0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            remaining_q     <= remaining_d;
            stride_q        <= stride_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            mem_q           <= mem_d;
            last_q          <= last_d;
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
        end
    end

    assign busy                 = busy_q;
    assign done                 = done_q;
    // Chip-select depends on this cycle's pop, so it is combinational.
    assign bus.sram_chipselect  = issue_c;
    assign bus.sram_address     = cur_addr_q;
    assign bus.sram_write       = 1'b0;
    assign bus.sram_byteenable  = 2'b11;
    assign bus.sram_clken       = 1'b1;
    assign bus.out_data         = mem_q[rd_ptr_q];
    assign bus.out_last         = last_q[rd_ptr_q];
    assign bus.out_valid        = (count_q != 2'd0);
endmodule

// File: tb/tb_npu_sram_stream_reader.sv
// Directed bench for npu_sram_stream_reader with a behavioural SRAM
// (mem[i] = 0x1000 + i, except mem[0x010..0x013] = 0xA000..0xA003).
module tb_npu_sram_stream_reader;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] length;
    logic [11:0] stride;
    logic        busy;
    logic        done;

    npu_sram_stream_reader_if #(.ADDR_W(12), .DATA_W(16)) bus ();

    npu_sram_stream_reader #(.ADDR_W(12), .DATA_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .stride    (stride),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [4096];
    always @(posedge clk) begin
        if (bus.sram_chipselect) bus.sram_readdata <= mem[bus.sram_address];
    end

    // Ready driver: held high, or the 1,0,0,1,0,1 pattern when bp_en is set.
    logic       bp_en = 1'b0;
    logic [5:0] bp_pat = 6'b101001;
    int         bp_idx = 0;
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            bus.out_ready = bp_pat[bp_idx];
            bp_idx = (bp_idx + 1) % 6;
        end else begin
            bus.out_ready = 1'b1;
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: logs handshakes and issues, tracks outstanding words and stalls.
    logic [15:0] data_log[$];
    logic        last_log[$];
    logic [11:0] addr_log[$];
    int          done_cnt, busy_cnt, credit_viol, stall_viol, outstanding, mon_pop;
    logic        stall_pend;
    logic [15:0] stall_data;
    logic        stall_last;

    always @(negedge clk) begin
        if (!reset_n) begin
            outstanding = 0;
            stall_pend  = 1'b0;
        end else begin
            mon_pop = (bus.out_valid && bus.out_ready) ? 1 : 0;
            if (outstanding > 2) credit_viol++;
            if (bus.sram_chipselect) begin
                addr_log.push_back(bus.sram_address);
                if (outstanding - mon_pop >= 2) credit_viol++;
            end
            if (stall_pend && (!bus.out_valid || bus.out_data !== stall_data || bus.out_last !== stall_last))
                stall_viol++;
            stall_pend = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
            stall_last = bus.out_last;
            if (mon_pop != 0) begin
                data_log.push_back(bus.out_data);
                last_log.push_back(bus.out_last);
            end
            if (done) done_cnt++;
            if (busy) busy_cnt++;
            outstanding = outstanding + (bus.sram_chipselect ? 1 : 0) - mon_pop;
        end
    end

    task automatic clear_logs();
        data_log.delete();
        last_log.delete();
        addr_log.delete();
        done_cnt = 0; busy_cnt = 0; credit_viol = 0; stall_viol = 0;
    endtask

    // Pulses start across one rising edge, then scribbles the command inputs.
    task automatic start_cmd(input logic [11:0] b, input logic [12:0] l, input logic [11:0] s);
        @(posedge clk); #1;
        start = 1'b1; base_addr = b; length = l; stride = s;
        @(posedge clk); #1;
        start = 1'b0; base_addr = 12'h555; length = 13'd7; stride = 12'd9;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_done"},  32'(done), 32'd0);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_last"},  32'(bus.out_last), 32'd0);
        check({tag, "_data"},  32'(bus.out_data), 32'd0);
        check({tag, "_cs"},    32'(bus.sram_chipselect), 32'd0);
        check({tag, "_addr"},  32'(bus.sram_address), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h1000 + 16'(i);
        for (int i = 0; i < 4; i++) mem[16 + i] = 16'hA000 + 16'(i);

        reset_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; stride = '0;
        clear_logs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        check("rst_write", 32'(bus.sram_write), 32'd0);
        check("rst_be",    32'(bus.sram_byteenable), 32'd3);
        check("rst_clken", 32'(bus.sram_clken), 32'd1);
        @(posedge clk); #1 reset_n = 1'b1;

        // Basic stream, cycle by cycle.
        clear_logs();
        start_cmd(12'h010, 13'd4, 12'd1);
        @(negedge clk);
        check("b_busy1", 32'(busy), 32'd1);
        check("b_cs1",   32'(bus.sram_chipselect), 32'd1);
        check("b_adr1",  32'(bus.sram_address), 32'h010);
        check("b_val1",  32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("b_adr2",  32'(bus.sram_address), 32'h011);
        check("b_val2",  32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("b_val",  32'(bus.out_valid), 32'd1);
            check("b_data", 32'(bus.out_data), 32'hA000 + 32'(i));
            check("b_last", 32'(bus.out_last), (i == 3) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("b_done",   32'(done), 32'd1);
        check("b_val_end", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("b_done_off", 32'(done), 32'd0);
        check("b_busy_off", 32'(busy), 32'd0);
        check("b_addrs_n",  32'(addr_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("b_addr", 32'(addr_log[i]), 32'h010 + 32'(i));
        check("b_done_cnt", 32'(done_cnt), 32'd1);

        // Backpressure.
        clear_logs();
        bp_en = 1'b1;
        start_cmd(12'h010, 13'd4, 12'd1);
        wait_done("bp_done_seen");
        bp_en = 1'b0;
        repeat (3) @(negedge clk);
        check("bp_n", 32'(data_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("bp_data", 32'(data_log[i]), 32'hA000 + 32'(i));
            check("bp_last", 32'(last_log[i]), (i == 3) ? 32'd1 : 32'd0);
        end
        check("bp_credit", 32'(credit_viol), 32'd0);
        check("bp_stall",  32'(stall_viol), 32'd0);
        check("bp_done_cnt", 32'(done_cnt), 32'd1);
        check("bp_issues", 32'(addr_log.size()), 32'd4);

        // Wrap and stride.
        clear_logs();
        start_cmd(12'hFFE, 13'd3, 12'd2);
        wait_done("wr_done_seen");
        repeat (2) @(negedge clk);
        check("wr_n",  32'(addr_log.size()), 32'd3);
        check("wr_a0", 32'(addr_log[0]), 32'hFFE);
        check("wr_a1", 32'(addr_log[1]), 32'h000);
        check("wr_a2", 32'(addr_log[2]), 32'h002);
        check("wr_d0", 32'(data_log[0]), 32'h1FFE);
        check("wr_d1", 32'(data_log[1]), 32'h1000);
        check("wr_d2", 32'(data_log[2]), 32'h1002);
        check("wr_l2", 32'(last_log[2]), 32'd1);

        // Zero length.
        clear_logs();
        start_cmd(12'h050, 13'd0, 12'd1);
        @(negedge clk);
        check("z_done", 32'(done), 32'd1);
        check("z_busy", 32'(busy), 32'd0);
        check("z_cs",   32'(bus.sram_chipselect), 32'd0);
        check("z_val",  32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("z_done_off", 32'(done), 32'd0);
        repeat (4) @(negedge clk);
        check("z_issues",   32'(addr_log.size()), 32'd0);
        check("z_words",    32'(data_log.size()), 32'd0);
        check("z_busy_cyc", 32'(busy_cnt), 32'd0);
        check("z_done_cnt", 32'(done_cnt), 32'd1);

        // Start while busy is ignored.
        clear_logs();
        start_cmd(12'h030, 13'd8, 12'd1);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; base_addr = 12'h100; length = 13'd4; stride = 12'd1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("ig_done_seen");
        repeat (10) @(negedge clk);
        check("ig_n",      32'(data_log.size()), 32'd8);
        check("ig_issues", 32'(addr_log.size()), 32'd8);
        for (int i = 0; i < 8; i++) check("ig_data", 32'(data_log[i]), 32'h1030 + 32'(i));
        check("ig_done_cnt", 32'(done_cnt), 32'd1);

        // Reset during the third word.
        clear_logs();
        start_cmd(12'h040, 13'd8, 12'd1);
        repeat (5) @(negedge clk);
        check("rm_pre_data", 32'(bus.out_data), 32'h1042);
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("rm");
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        clear_logs();
        @(negedge clk);
        check("rm_post_val", 32'(bus.out_valid), 32'd0);
        start_cmd(12'h020, 13'd2, 12'd1);
        wait_done("rm_done_seen");
        repeat (3) @(negedge clk);
        check("rm_n",  32'(data_log.size()), 32'd2);
        check("rm_d0", 32'(data_log[0]), 32'h1020);
        check("rm_d1", 32'(data_log[1]), 32'h1021);
        check("rm_l0", 32'(last_log[0]), 32'd0);
        check("rm_l1", 32'(last_log[1]), 32'd1);
        check("rm_done_cnt", 32'(done_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/npu_sram_stream_reader.md
# npu_sram_stream_reader

Read-side streaming engine sitting directly downstream of the 16-bit × 4096-word dual-port scratchpad SRAM. It drives the SRAM's second port (read-only use) to fetch a strided vector of 16-bit operands. It delivers the vector as a valid/ready stream to the NPU compute datapath. A 2-entry output buffer with credit-based issue absorbs the SRAM's 1-cycle read latency, so full 1-word/cycle throughput holds under arbitrary backpressure.

## Interface
- `ADDR_W`, default 12: SRAM word-address width (depth 2^ADDR_W).
- `DATA_W`, default 16: SRAM word width.
- `clk` in 1: the single clock; SRAM port 2 runs on the same clock.
- `reset_n` in 1: reset, asynchronous and active-low.
- `start` in 1: one-cycle command strobe; sampled only while `busy`=0.
- `base_addr` in ADDR_W: first word address; sampled with `start`.
- `length` in ADDR_W+1: number of words, 0..4096; sampled with `start`.
- `stride` in ADDR_W: address increment per word, modulo 2^ADDR_W; sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the command completes.
- `sram_address` out ADDR_W: drives SRAM port-2 address.
- `sram_chipselect` out 1: read request; high only in issue cycles.
- `sram_write` out 1: constant 0.
- `sram_byteenable` out 2: constant 2'b11.
- `sram_clken` out 1: constant 1.
- `sram_readdata` in DATA_W: SRAM port-2 data. Valid in the cycle after the issue cycle.
- `out_data` out DATA_W: stream data.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready from the consumer.
- `out_last` out 1: marks the final word of a command; qualified by `out_valid`.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE:
  - A `start` with `length`≠0 latches `cur_addr`=`base_addr`, `remaining`=`length`, `stride`, then moves to RUN.
  - A `start` with `length`=0 does not enter RUN, issues no reads and produces no output. `done` pulses on the next cycle; `busy` stays 0.
- RUN:
  - Issue condition each cycle: `count` + `inflight` − `pop` < 2, where `pop` = `out_valid`&`out_ready` and `inflight` ∈ {0,1} is the issue flag from the previous cycle.
  - On issue: `sram_chipselect`=1, `sram_address`=`cur_addr`. Then `cur_addr` += `stride` (wraps mod 4096, carry discarded) and `remaining` −= 1.
  - The issue of the word that takes `remaining` to 0 tags it as last. The FSM then moves to DRAIN.
- In-flight word: one cycle after issue, `sram_readdata` is captured into the 2-entry FIFO together with its last tag. The buffer never overflows because issue is credit-gated.
- Output: `out_data`/`out_last` come from the FIFO head; `out_valid` = FIFO non-empty.
  - While `out_valid`=1 and `out_ready`=0, `out_data`/`out_last` stay stable.
  - Push and pop in the same cycle leave `count` unchanged.
- DRAIN: no issues. When the last-tagged word is popped, `done` pulses and `busy` falls on the following cycle, and the FSM returns to IDLE.
- `start` while `busy`=1 is ignored.
- `base_addr`/`length`/`stride` changes after acceptance have no effect.
- Reset (asynchronous, any state): FSM→IDLE; FIFO emptied; `inflight` cleared. Data returned for an in-flight read after reset is discarded.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_last`=0, `out_data`=0, `sram_chipselect`=0, `sram_address`=0. Constant outputs hold their fixed values at all times.
- `start` sampled at edge E0. The first issue occurs in cycle E0→E1, and the SRAM registers the address at E1. `sram_readdata` is valid during E1→E2 and captured at E2. `out_valid` is first high during E2→E3, so first-word latency is 2 cycles.
- With `out_ready` held high, one word per cycle is delivered; a length-N command shows `out_valid` on N consecutive cycles.
- `done` is high in the cycle after the last-word handshake, and `busy` is 0 in the cycle after `done`. A new `start` is accepted in the `done` cycle at the earliest.

## Test plan
- Basic stream: SRAM mem[0x010..0x013]=0xA000..0xA003; start base=0x010, len=4, stride=1, ready=1.
  - Required: reads issued to 0x010..0x013 on consecutive cycles.
  - Required: `out_data` 0xA000..0xA003 on 4 consecutive cycles starting 2 cycles after `start`.
  - Required: `out_last` only on 0xA003; single `done` pulse.
- Backpressure: same command with `out_ready` toggling 1,0,0,1,0,1…
  - Required: every word delivered exactly once, in order, with data stable while stalled.
  - Required: `count`+`inflight` never exceeds 2, and no read is issued while the FIFO is full.
- Wrap and stride: base=0xFFE, len=3, stride=2.
  - Required: addresses issued are 0xFFE, 0x000, 0x002, and the corresponding data is streamed.
- Zero length: start len=0.
  - Required: no `sram_chipselect`, no `out_valid`, `done` pulses 1 cycle later, `busy` stays 0.
- Ignored start: while busy with len=8, assert `start` with base=0x100.
  - Required: the original 8 words only; exactly one `done`.
- Reset mid-run: deassert `reset_n` during the 3rd word of a len=8 command.
  - Required: all outputs go to reset values immediately.
  - Required: a later start base=0x020, len=2 streams exactly mem[0x020], mem[0x021] with no stale data.
